// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges several byte-stream requesters onto one UART transmit stream.
// A grant is held for a whole message (until tlast) and revoked if the owner stalls too long.
//
// state | meaning
// IDLE  | no owner; round-robin pick from the port after last_owner
// GRANT | one owner streams bytes into the output register until tlast or stall timeout
module uart_tx_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 125000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [PORTS-1:0]            grant,
  output logic                        timeout_event
);

  localparam int OW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int SW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STALL_MAX  = SW'(TIMEOUT - 1);
  localparam logic [OW-1:0] OWNER_INIT = OW'(PORTS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q, state_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           last_owner_q, last_owner_d;
  logic [SW-1:0]           stall_q, stall_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    m_valid_q, m_valid_d;
  logic                    timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0]   s_data_arr [PORTS];
  logic [OW-1:0]           cand;
  logic [OW-1:0]           pick;
  logic                    pick_found;
  logic                    out_free;
  logic                    own_valid;
  logic                    own_last;
  logic                    accept;

  for (genvar g = 0; g < PORTS; g++) begin : g_slice
    assign s_data_arr[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = OW'((int'(last_owner_q) + i) % PORTS);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  assign out_free  = !m_valid_q || m_axis_tready;
  assign own_valid = s_axis_tvalid[owner_q];
  assign own_last  = s_axis_tlast[owner_q];
  assign accept    = (state_q == GRANT) && own_valid && out_free;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    stall_d       = stall_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    m_valid_d     = m_valid_q;
    timeout_d     = 1'b0;
    s_axis_tready = '0;

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;
    if (accept) begin
      m_data_d  = s_data_arr[owner_q];
      m_last_d  = own_last;
      m_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (pick_found) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_axis_tready[owner_q] = out_free;
        // A tlast acceptance wins over a timeout that lands on the same cycle.
        if (accept && own_last) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          stall_d      = '0;
        end else if (accept) begin
          stall_d = '0;
        end else if (stall_q == STALL_MAX) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          stall_d      = '0;
          timeout_d    = 1'b1;
        end else if (!own_valid) begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OWNER_INIT;
      stall_q      <= '0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      stall_q      <= stall_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == GRANT) grant[owner_q] = 1'b1;
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign timeout_event = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: bytes are queued per requester, expected output is
// pushed when a requester handshake is driven and compared when the byte leaves m_axis.
module tb_uart_tx_arbiter;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int TO    = 16;

  logic              clk;
  logic              reset_n;
  logic [PORTS*DW-1:0] s_tdata;
  logic [PORTS-1:0]  s_tvalid;
  logic [PORTS-1:0]  s_tready;
  logic [PORTS-1:0]  s_tlast;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [PORTS-1:0]  grant;
  logic              timeout_event;

  uart_tx_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .grant         (grant),
    .timeout_event (timeout_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]       src_q [PORTS][$];
  logic [8:0]       exp_q [$];
  logic [PORTS-1:0] grant_log [$];
  logic [PORTS-1:0] prev_grant;
  int               n_checks;
  int               n_errors;
  int               n_out;
  int               n_timeouts;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < PORTS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[i*DW +: DW] = src_q[i][0][7:0];
        s_tlast[i]         = src_q[i][0][8];
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]         = 1'b0;
      end
    end
  endtask

  // Sample handshakes at the negedge, then advance the sources just after the posedge.
  task automatic cycle();
    logic [PORTS-1:0] hs;
    logic             mhs;
    logic [8:0]       e;
    @(negedge clk);
    hs  = s_tvalid & s_tready;
    mhs = m_tvalid & m_tready;
    if (mhs) begin
      chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_byte", 32'({m_tlast, m_tdata}), 32'(e));
      end
      n_out++;
    end
    if (timeout_event) n_timeouts++;
    if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
    prev_grant = grant;
    for (int i = 0; i < PORTS; i++) begin
      if (hs[i]) begin
        chk("hs_owner", 32'(grant[i]), 32'd1);
        exp_q.push_back(src_q[i][0]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < PORTS; i++) if (hs[i]) void'(src_q[i].pop_front());
    refresh();
  endtask

  function automatic logic busy();
    logic b;
    b = (exp_q.size() > 0) || m_tvalid || (grant != '0);
    for (int i = 0; i < PORTS; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (busy() && k < max_cycles) begin
      cycle();
      k++;
    end
    chk({tag, "_drained"}, 32'(k < max_cycles), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_rst_ctl"}, 32'({grant, s_tready, m_tvalid, m_tlast, timeout_event}), 32'd0);
    chk({tag, "_rst_data"}, 32'(m_tdata), 32'd0);
    exp_q.delete();
    for (int i = 0; i < PORTS; i++) src_q[i].delete();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    prev_grant = '0;
    grant_log.delete();
    n_out      = 0;
    n_timeouts = 0;
  endtask

  logic [PORTS-1:0] exp_order [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    prev_grant = '0;
    @(posedge clk);
    #1;

    // Basic 3-byte message from port 2.
    do_reset("t1");
    src_q[2].push_back(9'h041);
    src_q[2].push_back(9'h042);
    src_q[2].push_back(9'h143);
    refresh();
    #1;
    chk("t1_idle_ready", 32'(s_tready), 32'd0);
    chk("t1_idle_grant", 32'(grant), 32'd0);
    cycle();
    chk("t1_grant", 32'(grant), 32'h4);
    cycle();
    chk("t1_b0", 32'(m_tdata), 32'h41);
    cycle();
    chk("t1_b1", 32'({grant, m_tdata}), 32'h442);
    cycle();
    chk("t1_b2", 32'({grant, m_tlast, m_tdata}), 32'h143);
    drain("t1", 50);
    chk("t1_nout", 32'(n_out), 32'd3);

    // All ports request back-to-back single-byte messages.
    do_reset("t2");
    for (int i = 0; i < PORTS; i++) begin
      src_q[i].push_back(9'h150 + 9'(i));
      src_q[i].push_back(9'h160 + 9'(i));
    end
    refresh();
    drain("t2", 200);
    exp_order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    chk("t2_nlog", 32'(grant_log.size()), 32'd8);
    for (int j = 0; j < 8; j++)
      chk("t2_order", (grant_log.size() > j) ? 32'(grant_log[j]) : 32'hdead, 32'(exp_order[j]));
    chk("t2_nout", 32'(n_out), 32'd8);

    // Backpressure for 10 cycles in the middle of a port-0 message.
    do_reset("t3");
    for (int b = 0; b < 6; b++) src_q[0].push_back({(b == 5), 8'h10 + 8'(b)});
    refresh();
    cycle();
    cycle();
    cycle();
    m_tready = 1'b0;
    #1;
    chk("t3_own_ready", 32'(s_tready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t3_hold", 32'({grant, m_tvalid, m_tdata, s_tready}), {19'd0, 4'h1, 1'b1, 8'h11, 4'h0});
    end
    m_tready = 1'b1;
    drain("t3", 50);
    chk("t3_nout", 32'(n_out), 32'd6);

    // Port 1 stalls after one byte; port 3 waits behind it.
    do_reset("t4");
    src_q[1].push_back(9'h071);
    src_q[3].push_back(9'h173);
    refresh();
    cycle();
    chk("t4_grant", 32'(grant), 32'h2);
    cycle();
    for (int k = 0; k < TO - 1; k++) begin
      cycle();
      chk("t4_stall", 32'({timeout_event, grant}), 32'h02);
    end
    cycle();
    chk("t4_pulse", 32'({timeout_event, grant}), 32'h10);
    cycle();
    chk("t4_next", 32'({timeout_event, grant}), 32'h08);
    drain("t4", 50);
    chk("t4_ntimeouts", 32'(n_timeouts), 32'd1);
    chk("t4_nout", 32'(n_out), 32'd2);

    // Reset in the middle of a port-0 message.
    do_reset("t5a");
    for (int b = 0; b < 4; b++) src_q[0].push_back({(b == 3), 8'h21 + 8'(b)});
    refresh();
    cycle();
    cycle();
    cycle();
    chk("t5_busy", 32'({grant, m_tvalid}), 32'h3);
    do_reset("t5b");
    src_q[0].push_back(9'h12a);
    refresh();
    cycle();
    chk("t5_regrant", 32'(grant), 32'h1);
    drain("t5", 50);
    chk("t5_nout", 32'(n_out), 32'd1);

    // tlast accepted exactly when the stall counter sits at its limit.
    do_reset("t6");
    src_q[1].push_back(9'h081);
    refresh();
    cycle();
    cycle();
    for (int k = 0; k < TO - 1; k++) begin
      cycle();
      chk("t6_stall", 32'({timeout_event, grant}), 32'h02);
    end
    src_q[1].push_back(9'h182);
    refresh();
    cycle();
    chk("t6_release", 32'({timeout_event, grant}), 32'h00);
    chk("t6_byte", 32'({m_tlast, m_tdata}), 32'h182);
    cycle();
    chk("t6_nopulse", 32'(timeout_event), 32'd0);
    drain("t6", 50);
    chk("t6_ntimeouts", 32'(n_timeouts), 32'd0);
    chk("t6_nout", 32'(n_out), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width.
REQ-003 SHALL have parameter TIMEOUT, default 125000, idle cycles before a stalled grant is revoked (>=2).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_axis_tdata  input  PORTS*DATA_WIDTH  requester bytes; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port s_axis_tvalid  input  PORTS  per-requester valid.
REQ-008 SHALL have port s_axis_tready  output  PORTS  per-requester ready.
REQ-009 SHALL have port s_axis_tlast  input  PORTS  last byte of a message.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  byte to the UART transmitter.
REQ-011 SHALL have port m_axis_tvalid  output  1  output byte valid.
REQ-012 SHALL have port m_axis_tready  input  1  UART transmitter ready.
REQ-013 SHALL have port m_axis_tlast  output  1  tlast of the held byte.
REQ-014 SHALL have port grant  output  PORTS  one-hot current owner; all zero when idle.
REQ-015 SHALL have port timeout_event  output  1  one-cycle pulse on grant revocation.

Function
REQ-016 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-017 SHALL, in IDLE with any s_axis_tvalid high, select an owner by round-robin starting at index (last_owner+1) mod PORTS, and enter GRANT with grant one-hot on the next cycle.
REQ-018 SHALL hold s_axis_tready all zero in IDLE.
REQ-019 SHALL, in GRANT, drive s_axis_tready[owner] = !m_axis_tvalid || m_axis_tready; all other ready bits 0.
REQ-020 SHALL register an accepted byte and its tlast into the output register on the cycle after the s_axis handshake: one-cycle latency, no combinational path from s_axis to m_axis.
REQ-021 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 SHALL clear m_axis_tvalid after an m_axis handshake unless a new byte is accepted in the same cycle; this sustains one byte per cycle when m_axis_tready stays high.
REQ-023 SHALL, when the owner's byte with tlast=1 is accepted, return to IDLE on the next cycle with grant=0; the byte still drains from the output register.
REQ-024 SHALL let IDLE re-arbitrate while the output register drains; new bytes wait on REQ-019.
REQ-025 SHALL keep a stall counter in GRANT that increments each cycle s_axis_tvalid[owner]=0 and clears on any accepted owner byte and on GRANT entry.
REQ-026 SHALL, when the stall counter reaches TIMEOUT-1, revoke the grant (to IDLE next cycle) and pulse timeout_event for exactly one cycle; if a tlast acceptance happens in that same cycle, release normally with no pulse.
REQ-027 SHALL record last_owner at every release, both tlast and timeout.
REQ-028 SHALL ignore tvalid changes of non-owners while in GRANT.
REQ-029 SHALL size the stall counter to $clog2(TIMEOUT) bits, with no wrap before TIMEOUT-1.

Reset
REQ-030 SHALL, while reset_n=0, force state=IDLE, grant=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, timeout_event=0, stall counter=0, last_owner=PORTS-1, so port 0 wins first.
REQ-031 SHALL discard any byte in the output register when reset is asserted mid-message, and resume from IDLE on release.

Verification
REQ-032 SHALL cover: port 2 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready=1 -> grant=0100 one cycle after tvalid, bytes appear in order one per cycle, grant=0 the cycle after 0x43 is accepted.
REQ-033 SHALL cover: all 4 ports request continuously with 1-byte messages after reset -> grant order 0,1,2,3,0.
REQ-034 SHALL cover: m_axis_tready=0 for 10 cycles mid-message -> m_axis_tdata holds its value, owner tready=0, no bytes lost or duplicated.
REQ-035 SHALL cover: TIMEOUT=16, port 1 sends one byte without tlast then drops tvalid -> timeout_event pulses exactly once 16 cycles after the last accepted byte, grant goes 0, port 3 waiting then gets grant.
REQ-036 SHALL cover: reset_n pulsed low during a port-0 message -> all outputs reach their reset values immediately; after release, port 0 requesting is granted again.
REQ-037 SHALL cover: owner's tlast accepted on the same cycle the stall counter would reach TIMEOUT-1 -> normal release with timeout_event=0.
